// File: rtl/add_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : add_accumulator
// Brief    : Registered accumulation stage behind an N-bit adder; collects a
//            frame of operands and hands sum, carry count and sticky overflow
//            to a consumer over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module add_accumulator #(
    parameter int N   = 4,
    parameter int LEN = 8,
    parameter int SAT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic                     op_last,
    output logic [N-1:0]             acc_out,
    input  logic [N-1:0]             sum_in,
    input  logic                     cout_in,
    input  logic                     ovf_in,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N-1:0]             res_sum,
    output logic [$clog2(LEN+1)-1:0] res_ccnt,
    output logic                     res_ovf,
    output logic [$clog2(LEN+1)-1:0] res_cnt
);

    localparam int CW = $clog2(LEN+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_ccnt;
    logic            r_ovf;
    logic            r_op_ready;
    logic            r_res_valid;

    logic            w_accept;
    logic            w_close;
    logic [CW-1:0]   w_cnt_inc;
    logic [N-1:0]    w_acc_next;

    assign w_accept  = op_valid && r_op_ready;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_close   = op_last || (w_cnt_inc == CW'(LEN));

    generate
        if (SAT != 0) begin : g_sat
            // Sign of the wrapped sum tells the overflow direction.
            always_comb begin
                w_acc_next = sum_in;
                if (ovf_in) begin
                    w_acc_next = sum_in[N-1] ? {1'b0, {(N-1){1'b1}}}
                                             : {1'b1, {(N-1){1'b0}}};
                end
            end
        end else begin : g_wrap
            assign w_acc_next = sum_in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ccnt      <= '0;
            r_ovf       <= 1'b0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    r_op_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc  <= w_acc_next;
                        r_cnt  <= w_cnt_inc;
                        r_ccnt <= r_ccnt + CW'(cout_in);
                        r_ovf  <= r_ovf | ovf_in;
                        if (w_close) begin
                            r_state     <= S_HOLD;
                            r_op_ready  <= 1'b0;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ccnt      <= '0;
                        r_ovf       <= 1'b0;
                        r_op_ready  <= 1'b1;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_op_ready  <= 1'b1;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready  = r_op_ready;
    assign res_valid = r_res_valid;
    assign acc_out   = r_acc;
    assign res_sum   = r_acc;
    assign res_cnt   = r_cnt;
    assign res_ccnt  = r_ccnt;
    assign res_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_accumulator
// Brief    : Directed frame table driving a wrapping and a saturating instance.
// Revision : 1.0
// ============================================================================
module tb_add_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_last;
    logic       res_ready;
    logic [3:0] y;

    // Wrapping instance (SAT = 0)
    logic       rdy0, val0, cout0, ovf0, rovf0;
    logic [3:0] acc0, sum0, rsum0, ccnt0, cnt0;
    // Saturating instance (SAT = 1)
    logic       rdy1, val1, cout1, ovf1, rovf1;
    logic [3:0] acc1, sum1, rsum1, ccnt1, cnt1;

    always #5 clk = ~clk;

    // Upstream adder seen by each instance
    assign {cout0, sum0} = {1'b0, acc0} + {1'b0, y};
    assign ovf0 = (acc0[3] == y[3]) && (sum0[3] != acc0[3]);
    assign {cout1, sum1} = {1'b0, acc1} + {1'b0, y};
    assign ovf1 = (acc1[3] == y[3]) && (sum1[3] != acc1[3]);

    add_accumulator #(.N(4), .LEN(8), .SAT(0)) u_dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(rdy0),
        .op_last(op_last), .acc_out(acc0), .sum_in(sum0), .cout_in(cout0),
        .ovf_in(ovf0), .res_valid(val0), .res_ready(res_ready),
        .res_sum(rsum0), .res_ccnt(ccnt0), .res_ovf(rovf0), .res_cnt(cnt0)
    );

    add_accumulator #(.N(4), .LEN(8), .SAT(1)) u_dut_sat (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(rdy1),
        .op_last(op_last), .acc_out(acc1), .sum_in(sum1), .cout_in(cout1),
        .ovf_in(ovf1), .res_valid(val1), .res_ready(res_ready),
        .res_sum(rsum1), .res_ccnt(ccnt1), .res_ovf(rovf1), .res_cnt(cnt1)
    );

    // ops: first operand in the top nibble
    typedef struct packed {
        logic [3:0]  nops;
        logic        last;
        logic [31:0] ops;
        logic [3:0]  s0;
        logic [3:0]  c0;
        logic [3:0]  cc0;
        logic        o0;
        logic [3:0]  s1;
        logic [3:0]  cc1;
        logic        o1;
    } frame_t;

    frame_t frames [8];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic frame_t mk(input logic [3:0] n, input logic l, input logic [31:0] o,
                                  input logic [3:0] s0, input logic [3:0] c0,
                                  input logic [3:0] cc0, input logic o0,
                                  input logic [3:0] s1, input logic [3:0] cc1,
                                  input logic o1);
        frame_t f;
        f.nops = n; f.last = l; f.ops = o;
        f.s0 = s0; f.c0 = c0; f.cc0 = cc0; f.o0 = o0;
        f.s1 = s1; f.cc1 = cc1; f.o1 = o1;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int idx);
        frame_t f;
        f = frames[idx];
        for (int i = 0; i < int'(f.nops); i++) begin
            op_valid = 1'b1;
            y        = f.ops[31-4*i -: 4];
            op_last  = f.last && (i == int'(f.nops) - 1);
            tick();
            if (i < int'(f.nops) - 1) begin
                check($sformatf("f%0d_mid_valid%0d", idx, i), {31'd0, val0}, 32'd0);
            end
        end
        op_valid = 1'b0;
        op_last  = 1'b0;
        check($sformatf("f%0d_valid", idx),     {31'd0, val0},  32'd1);
        check($sformatf("f%0d_valid_sat", idx), {31'd0, val1},  32'd1);
        check($sformatf("f%0d_ready", idx),     {31'd0, rdy0},  32'd0);
        check($sformatf("f%0d_sum", idx),       {28'd0, rsum0}, {28'd0, f.s0});
        check($sformatf("f%0d_cnt", idx),       {28'd0, cnt0},  {28'd0, f.c0});
        check($sformatf("f%0d_ccnt", idx),      {28'd0, ccnt0}, {28'd0, f.cc0});
        check($sformatf("f%0d_ovf", idx),       {31'd0, rovf0}, {31'd0, f.o0});
        check($sformatf("f%0d_sum_sat", idx),   {28'd0, rsum1}, {28'd0, f.s1});
        check($sformatf("f%0d_cnt_sat", idx),   {28'd0, cnt1},  {28'd0, f.c0});
        check($sformatf("f%0d_ccnt_sat", idx),  {28'd0, ccnt1}, {28'd0, f.cc1});
        check($sformatf("f%0d_ovf_sat", idx),   {31'd0, rovf1}, {31'd0, f.o1});
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_rel_valid"}, {31'd0, val0}, 32'd0);
        check({tag, "_rel_acc"},   {28'd0, acc0}, 32'd0);
        check({tag, "_rel_acc_s"}, {28'd0, acc1}, 32'd0);
        check({tag, "_rel_cnt"},   {28'd0, cnt0}, 32'd0);
        check({tag, "_rel_ready"}, {31'd0, rdy0}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //                 n  last ops            s0   c0  cc0 o0   s1   cc1 o1
        frames[0] = mk(4'd3, 1'b1, 32'h3210_0000, 4'h6, 4'd3, 4'd0, 1'b0, 4'h6, 4'd0, 1'b0);
        frames[1] = mk(4'd2, 1'b1, 32'h7100_0000, 4'h8, 4'd2, 4'd0, 1'b1, 4'h7, 4'd0, 1'b1);
        frames[2] = mk(4'd2, 1'b1, 32'h8F00_0000, 4'h7, 4'd2, 4'd1, 1'b1, 4'h8, 4'd1, 1'b1);
        frames[3] = mk(4'd3, 1'b1, 32'h7110_0000, 4'h9, 4'd3, 4'd0, 1'b1, 4'h7, 4'd0, 1'b1);
        frames[4] = mk(4'd8, 1'b0, 32'h1111_1111, 4'h8, 4'd8, 4'd0, 1'b1, 4'h7, 4'd0, 1'b1);
        frames[5] = mk(4'd3, 1'b1, 32'hFFF0_0000, 4'hD, 4'd3, 4'd2, 1'b0, 4'hD, 4'd2, 1'b0);
        frames[6] = mk(4'd1, 1'b1, 32'h5000_0000, 4'h5, 4'd1, 4'd0, 1'b0, 4'h5, 4'd0, 1'b0);
        frames[7] = mk(4'd8, 1'b1, 32'h2222_2222, 4'h0, 4'd8, 4'd1, 1'b1, 4'h7, 4'd0, 1'b1);

        rst = 1'b1; op_valid = 1'b0; op_last = 1'b0; res_ready = 1'b0; y = 4'h0;
        tick();
        tick();
        check("rst_ready", {31'd0, rdy0},  32'd0);
        check("rst_valid", {31'd0, val0},  32'd0);
        check("rst_acc",   {28'd0, acc0},  32'd0);
        check("rst_sum",   {28'd0, rsum0}, 32'd0);
        check("rst_cnt",   {28'd0, cnt0},  32'd0);
        check("rst_ccnt",  {28'd0, ccnt0}, 32'd0);
        check("rst_ovf",   {31'd0, rovf0}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, rdy0}, 32'd1);

        for (int k = 0; k < 8; k++) begin
            run_frame(k);
            release_result($sformatf("f%0d", k));
        end

        // Backpressure with an extra operand offered while holding
        run_frame(4);
        op_valid = 1'b1;
        y        = 4'h1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_ready%0d", c), {31'd0, rdy0},  32'd0);
            check($sformatf("bp_valid%0d", c), {31'd0, val0},  32'd1);
            check($sformatf("bp_sum%0d", c),   {28'd0, rsum0}, 32'h8);
            check($sformatf("bp_cnt%0d", c),   {28'd0, cnt0},  32'd8);
        end
        op_valid = 1'b0;
        release_result("bp");

        // Reset after two accepts
        op_valid = 1'b1; y = 4'h3; tick();
        y = 4'h2; tick();
        check("mid_acc", {28'd0, acc0}, 32'h5);
        op_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_acc",   {28'd0, acc0}, 32'd0);
        check("mid_rst_cnt",   {28'd0, cnt0}, 32'd0);
        check("mid_rst_ready", {31'd0, rdy0}, 32'd0);
        check("mid_rst_valid", {31'd0, val0}, 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_ready_back", {31'd0, rdy0}, 32'd1);
        run_frame(0);
        release_result("after_mid_rst");

        // Reset while holding a result
        run_frame(6);
        rst = 1'b1;
        tick();
        check("hold_rst_valid", {31'd0, val0},  32'd0);
        check("hold_rst_sum",   {28'd0, rsum0}, 32'd0);
        check("hold_rst_cnt",   {28'd0, cnt0},  32'd0);
        check("hold_rst_ovf",   {31'd0, rovf0}, 32'd0);
        rst = 1'b0;
        tick();
        run_frame(1);
        release_result("after_hold_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_accumulator.md
Name: add_accumulator

Overview:
- Registered accumulation stage directly downstream of the parameterised N-bit combinational adder.
- Drives the adder's x operand from its accumulator register and captures the adder's sum, carry-out and signed-overflow each time an operand is accepted.
- Accumulates a frame of operands, then presents the final sum, a carry count and a sticky overflow flag to a consumer through a valid/ready handshake.

Parameters:
- N, 4, operand/accumulator width; must match the adder's n.
- LEN, 8, maximum operands per frame (LEN >= 1); the frame closes at LEN operands even if op_last is never asserted.
- SAT, 0, 1 = clamp the accumulator to the signed range on overflow; 0 = wrap modulo 2^N.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  upstream operand valid; operand y is presented to the adder directly by upstream.
- op_ready  out  1  operand accepted when op_valid && op_ready.
- op_last  in  1  marks the final operand of a frame; qualified by the handshake.
- acc_out  out  N  accumulator register; wired to the adder's x input.
- sum_in  in  N  adder s.
- cout_in  in  1  adder cout.
- ovf_in  in  1  adder overflow (signed).
- res_valid  out  1  frame result valid.
- res_ready  in  1  consumer ready.
- res_sum  out  N  final accumulator value.
- res_ccnt  out  $clog2(LEN+1)  number of accepted operands whose cout_in was 1.
- res_ovf  out  1  sticky: 1 if any accepted operand in the frame had ovf_in = 1.
- res_cnt  out  $clog2(LEN+1)  operands in the frame.

Behaviour:
- Reset: clk and rst as named; rst is synchronous and active-high, sampled on the rising edge of clk.
  - State goes to IDLE.
  - acc_out, res_sum, res_ccnt, res_cnt and res_ovf are all 0.
  - res_valid = 0, op_ready = 0 during the reset cycle, then 1.
  - rst overrides every other event, including mid-frame and during HOLD; a pending result is discarded.
- op_ready is a function of state only, with no combinational path from op_valid: 1 in IDLE and ACC, 0 in HOLD.
- res_valid = 1 exactly in HOLD.
- State IDLE (empty frame, acc = 0): on accept, update the frame state as below, then go to ACC, or straight to HOLD if op_last or LEN == 1.
- State ACC: on accept, update as below; go to HOLD if op_last or res_cnt+1 == LEN; otherwise stay. No accept means no change.
- Update on accept:
  - acc <= sum_in, or its clamped value when SAT = 1 and ovf_in = 1: sum_in[N-1] = 1 gives positive overflow, clamp to 2^(N-1)-1; sum_in[N-1] = 0 gives negative overflow, clamp to -2^(N-1).
  - cnt += 1.
  - ccnt += cout_in.
  - ovf <= ovf | ovf_in.
- State HOLD: res_* are stable while res_valid && !res_ready. On res_ready, go to IDLE; acc, cnt, ccnt and ovf clear to 0 in the same edge.
- Latency: result visible one cycle after the closing operand's accept edge. One idle cycle (IDLE) separates frames. Throughput is 1 operand/cycle within a frame.
- res_sum mirrors acc_out; res_cnt/res_ccnt/res_ovf mirror the internal counters. The counters cannot exceed LEN by construction.
- Arithmetic is two's complement, N bits. Wrap is allowed when SAT = 0, with res_ovf still flagged. After a clamp, accumulation continues from the clamped value.
- op_last on the LEN-th operand is redundant: a single HOLD, no double close.

Test Plan:
- N=4, SAT=0: ops 3,2,1 with op_last on 1 → res_valid in the cycle after the third accept; res_sum=6, res_cnt=3, res_ccnt=0, res_ovf=0.
- N=4, SAT=0: ops 7,1 → acc 7→8 (0b1000) → res_sum=8, res_ovf=1. Then ops -8,-1 (0b1000,0b1111) → res_sum=7, res_ccnt=1, res_ovf=1.
- N=4, SAT=1: ops 7,1,1 → acc 7, clamp at 7, 7+1 clamps again → res_sum=7, res_ovf=1. Ops -8,-1 → res_sum=-8 (0b1000).
- LEN=8, no op_last, 8 ops of 1 → frame closes on the 8th accept; res_cnt=8, res_sum=8 (SAT=0, N=4, wraps to 0b1000), res_ovf=1. A 9th op_valid sees op_ready=0.
- Backpressure: hold res_ready=0 for 5 cycles in HOLD → res_* are constant and op_ready=0. Assert res_ready → next cycle IDLE with acc_out=0 and op_ready=1.
- Reset mid-frame after 2 accepts, and again while in HOLD → next cycle all outputs are 0, res_valid=0, and a new frame starts from acc=0.
